// File: rtl/motoro3_step_generator_p_if.sv
// Control and status bundle between the motor control registers and the
// three-phase step generator.
interface motoro3_step_generator_p_if #(
  parameter int CNT_W  = 25,
  parameter int STEP_W = 4,
  parameter int REV_W  = 32
);
  logic              m3start;
  logic              m3dir;
  logic [CNT_W-1:0]  m3period;
  logic [STEP_W-1:0] m3stepA;
  logic [STEP_W-1:0] m3stepB;
  logic [STEP_W-1:0] m3stepC;
  logic [CNT_W-1:0]  m3cnt;
  logic              m3cntLast1;
  logic              m3stepPulse;
  logic [REV_W-1:0]  m3revCnt;
  logic              m3busy;

  modport master (
    output m3start, m3dir, m3period,
    input  m3stepA, m3stepB, m3stepC, m3cnt, m3cntLast1, m3stepPulse,
           m3revCnt, m3busy
  );

  modport slave (
    input  m3start, m3dir, m3period,
    output m3stepA, m3stepB, m3stepC, m3cnt, m3cntLast1, m3stepPulse,
           m3revCnt, m3busy
  );
endinterface

// File: rtl/motoro3_step_generator_p.sv
// Three-phase step sequencer: one step down-counter drives phase A, with B and
// C derived combinationally as fixed offsets of a third of a cycle.
module motoro3_step_generator_p #(
  parameter int CNT_W  = 25,
  parameter int STEP_W = 4,
  parameter int STEPS  = 12,
  parameter int REV_W  = 32
) (
  input  logic                        clk,
  input  logic                        nRst,
  motoro3_step_generator_p_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOPPING
  } state_t;

  localparam int                 THIRD   = STEPS / 3;
  localparam int                 SUM_W   = STEP_W + 1;
  localparam logic [STEP_W-1:0]  STEPS_L = STEP_W'(STEPS);
  localparam logic [STEP_W-1:0]  ONE_L   = STEP_W'(1);
  localparam logic [SUM_W-1:0]   STEPS_S = SUM_W'(STEPS);

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REV_W-1:0]    rev_q, rev_d;
  logic                start_prev_q, start_prev_d;

  logic                busy;
  logic                last1;
  logic                start_up;
  logic                advance;
  logic                wrap;
  logic [STEP_W-1:0]   step_next;
  logic [CNT_W-1:0]    period_clamped;
  logic [SUM_W-1:0]    b_sum, c_sum;
  logic [STEP_W-1:0]   step_b, step_c;

  // All motor-path registers move on the falling clock edge.
  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      cnt_q        <= '0;
      rev_q        <= '0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      cnt_q        <= cnt_d;
      rev_q        <= rev_d;
      start_prev_q <= start_prev_d;
    end
  end

  always_comb begin
    busy           = (state_q != S_IDLE);
    last1          = busy & (cnt_q[CNT_W-1:1] == '0);
    start_up       = bus.m3start & ~start_prev_q;
    start_prev_d   = bus.m3start;
    period_clamped = (bus.m3period[CNT_W-1:1] == '0) ? CNT_W'(2) : bus.m3period;
    // A stop cancelled right on the final cycle still takes the step as a run.
    advance        = last1 & ((state_q == S_RUN) |
                              ((state_q == S_STOPPING) & bus.m3start));
    wrap           = bus.m3dir ? (step_q == ONE_L) : (step_q == STEPS_L);
    if (bus.m3dir) begin
      step_next = wrap ? STEPS_L : step_q - ONE_L;
    end else begin
      step_next = wrap ? ONE_L : step_q + ONE_L;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start_up) state_d = S_RUN;
      S_RUN:      if (!bus.m3start) state_d = S_STOPPING;
      S_STOPPING: begin
        if (bus.m3start) begin
          state_d = S_RUN;
        end else if (last1) begin
          state_d = S_IDLE;
        end
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_comb begin
    step_d = step_q;
    cnt_d  = cnt_q;
    rev_d  = rev_q;
    case (state_q)
      S_IDLE: begin
        if (start_up) begin
          step_d = ONE_L;
          cnt_d  = period_clamped;
          rev_d  = '0;
        end else begin
          step_d = '0;
          cnt_d  = '0;
        end
      end
      S_RUN, S_STOPPING: begin
        if (advance) begin
          step_d = step_next;
          cnt_d  = period_clamped;
          if (wrap && (rev_q != '1)) rev_d = rev_q + REV_W'(1);
        end else if (last1) begin
          step_d = '0;
          cnt_d  = '0;
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        step_d = '0;
        cnt_d  = '0;
      end
    endcase
  end

  // Phase offsets never exceed one cycle, so a single conditional subtract wraps them.
  always_comb begin
    b_sum  = {1'b0, step_q} + SUM_W'(2 * THIRD);
    c_sum  = {1'b0, step_q} + SUM_W'(THIRD);
    step_b = '0;
    step_c = '0;
    if (step_q > STEPS_L) begin
      step_b = '1;
      step_c = '1;
    end else if (step_q != '0) begin
      step_b = (b_sum > STEPS_S) ? STEP_W'(b_sum - STEPS_S) : STEP_W'(b_sum);
      step_c = (c_sum > STEPS_S) ? STEP_W'(c_sum - STEPS_S) : STEP_W'(c_sum);
    end
  end

  assign bus.m3stepA     = step_q;
  assign bus.m3stepB     = step_b;
  assign bus.m3stepC     = step_c;
  assign bus.m3cnt       = cnt_q;
  assign bus.m3cntLast1  = last1;
  assign bus.m3stepPulse = advance;
  assign bus.m3revCnt    = rev_q;
  assign bus.m3busy      = busy;

endmodule

// File: tb/tb_motoro3_step_generator_p.sv
// Scoreboard bench for the step generator: a 12-step and a 6-step instance share
// stimulus and are both checked against a cycle-level behavioural model.
module tb_motoro3_step_generator_p;

  typedef struct {
    int     a;
    int     b;
    int     c;
    int     cnt;
    bit     last1;
    bit     pulse;
    bit     busy;
    longint rev;
  } exp_t;

  localparam longint REV_MAX = 64'h0000_0000_FFFF_FFFF;

  logic clk;
  logic nRst;

  motoro3_step_generator_p_if #(.CNT_W(25), .STEP_W(4), .REV_W(32)) bus12 ();
  motoro3_step_generator_p_if #(.CNT_W(25), .STEP_W(3), .REV_W(32)) bus6 ();

  motoro3_step_generator_p #(.CNT_W(25), .STEP_W(4), .STEPS(12), .REV_W(32)) u_dut12 (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus12)
  );

  motoro3_step_generator_p #(.CNT_W(25), .STEP_W(3), .STEPS(6), .REV_W(32)) u_dut6 (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus6)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  exp_t   q_exp [2][$];
  int     vectors     = 0;
  int     miscompares = 0;

  // Model state: mode 0 idle, 1 running, 2 stop requested.
  int     steps_of [2] = '{12, 6};
  int     m_mode   [2];
  int     m_idx    [2];
  int     m_rem    [2];
  longint m_rev    [2];
  bit     m_prev   [2];

  bit     cur_start;
  bit     cur_dir;
  int     cur_period;

  function automatic int phase(input int a, input int s, input int off);
    if (a == 0) return 0;
    return ((a - 1 + off) % s) + 1;
  endfunction

  function automatic void model_cycle(input int k, input bit rst_n, input bit st,
                                      input bit dr, input int per, output exp_t e);
    int s;
    int len;
    bit last;
    bit adv;
    bit wrapped;
    s = steps_of[k];
    e = '{default: 0};
    if (!rst_n) begin
      m_mode[k] = 0;
      m_idx[k]  = 0;
      m_rem[k]  = 0;
      m_rev[k]  = 0;
      m_prev[k] = 0;
      return;
    end
    len     = (per < 2) ? 2 : per;
    e.busy  = (m_mode[k] != 0);
    last    = e.busy && (m_rem[k] <= 1);
    adv     = last && ((m_mode[k] == 1) || st);
    e.last1 = last;
    e.pulse = adv;
    e.a     = m_idx[k];
    e.b     = phase(m_idx[k], s, 2 * s / 3);
    e.c     = phase(m_idx[k], s, s / 3);
    e.cnt   = m_rem[k];
    e.rev   = m_rev[k];
    if (m_mode[k] == 0) begin
      if (st && !m_prev[k]) begin
        m_mode[k] = 1;
        m_idx[k]  = 1;
        m_rem[k]  = len;
        m_rev[k]  = 0;
      end
    end else if (adv) begin
      wrapped  = dr ? (m_idx[k] == 1) : (m_idx[k] == s);
      if (dr) m_idx[k] = wrapped ? s : m_idx[k] - 1;
      else    m_idx[k] = wrapped ? 1 : m_idx[k] + 1;
      m_rem[k] = len;
      if (wrapped && m_rev[k] < REV_MAX) m_rev[k] = m_rev[k] + 1;
      m_mode[k] = st ? 1 : 2;
    end else if (last) begin
      m_mode[k] = 0;
      m_idx[k]  = 0;
      m_rem[k]  = 0;
    end else begin
      m_rem[k]  = m_rem[k] - 1;
      m_mode[k] = st ? 1 : 2;
    end
    m_prev[k] = st;
  endfunction

  // One clock cycle of stimulus: drive just after the active (falling) edge.
  task automatic applyStimulus(input bit rst_n, input bit st, input bit dr, input int per);
    exp_t e;
    @(negedge clk);
    #1;
    nRst           = rst_n;
    bus12.m3start  = st;
    bus12.m3dir    = dr;
    bus12.m3period = 25'(per);
    bus6.m3start   = st;
    bus6.m3dir     = dr;
    bus6.m3period  = 25'(per);
    for (int k = 0; k < 2; k++) begin
      model_cycle(k, rst_n, st, dr, per, e);
      q_exp[k].push_back(e);
    end
  endtask

  task automatic run_cycles(input int n, input bit st, input bit dr, input int per);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, st, dr, per);
  endtask

  task automatic checkOutput(input int k, input exp_t e);
    int     a, b, c, cnt;
    bit     l1, pu, bz;
    longint rev;
    bit     bad;
    string  nm;
    if (k == 0) begin
      nm = "S12"; a = int'(bus12.m3stepA); b = int'(bus12.m3stepB); c = int'(bus12.m3stepC);
      cnt = int'(bus12.m3cnt); l1 = bus12.m3cntLast1; pu = bus12.m3stepPulse;
      bz = bus12.m3busy; rev = longint'(bus12.m3revCnt);
    end else begin
      nm = "S6"; a = int'(bus6.m3stepA); b = int'(bus6.m3stepB); c = int'(bus6.m3stepC);
      cnt = int'(bus6.m3cnt); l1 = bus6.m3cntLast1; pu = bus6.m3stepPulse;
      bz = bus6.m3busy; rev = longint'(bus6.m3revCnt);
    end
    bad = 1'b0;
    vectors++;
    if (a != e.a)         begin bad = 1; $display("[TB] FAIL %s stepA t=%0t: got %0d expected %0d", nm, $time, a, e.a); end
    if (b != e.b)         begin bad = 1; $display("[TB] FAIL %s stepB t=%0t: got %0d expected %0d", nm, $time, b, e.b); end
    if (c != e.c)         begin bad = 1; $display("[TB] FAIL %s stepC t=%0t: got %0d expected %0d", nm, $time, c, e.c); end
    if (cnt != e.cnt)     begin bad = 1; $display("[TB] FAIL %s cnt t=%0t: got %0d expected %0d", nm, $time, cnt, e.cnt); end
    if (l1 != e.last1)    begin bad = 1; $display("[TB] FAIL %s cntLast1 t=%0t: got %0d expected %0d", nm, $time, l1, e.last1); end
    if (pu != e.pulse)    begin bad = 1; $display("[TB] FAIL %s stepPulse t=%0t: got %0d expected %0d", nm, $time, pu, e.pulse); end
    if (bz != e.busy)     begin bad = 1; $display("[TB] FAIL %s busy t=%0t: got %0d expected %0d", nm, $time, bz, e.busy); end
    if (rev != e.rev)     begin bad = 1; $display("[TB] FAIL %s revCnt t=%0t: got %0d expected %0d", nm, $time, rev, e.rev); end
    if (bad) miscompares++;
  endtask

  // Monitor samples mid-cycle, away from the falling edge that updates the DUT.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (q_exp[k].size() > 0) checkOutput(k, q_exp[k].pop_front());
    end
  end

  initial begin
    nRst           = 1'b0;
    bus12.m3start  = 1'b0;
    bus12.m3dir    = 1'b0;
    bus12.m3period = '0;
    bus6.m3start   = 1'b0;
    bus6.m3dir     = 1'b0;
    bus6.m3period  = '0;

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 4);
    run_cycles(2, 1'b0, 1'b0, 4);

    $display("[TB] forward run, P=4");
    run_cycles(54, 1'b1, 1'b0, 4);
    run_cycles(6, 1'b0, 1'b0, 4);

    $display("[TB] reverse run, P=4");
    run_cycles(30, 1'b1, 1'b1, 4);
    run_cycles(6, 1'b0, 1'b1, 4);

    $display("[TB] clamped periods 0 and 1");
    run_cycles(10, 1'b1, 1'b0, 0);
    run_cycles(10, 1'b1, 1'b0, 1);
    run_cycles(4, 1'b0, 1'b0, 1);

    $display("[TB] period change 4 -> 8 mid-step");
    run_cycles(3, 1'b1, 1'b0, 4);
    run_cycles(20, 1'b1, 1'b0, 8);
    run_cycles(10, 1'b0, 1'b0, 8);

    $display("[TB] stop during step 5, then cancelled stop");
    run_cycles(1, 1'b0, 1'b0, 4);
    run_cycles(18, 1'b1, 1'b0, 4);
    run_cycles(5, 1'b0, 1'b0, 4);
    run_cycles(18, 1'b1, 1'b0, 4);
    run_cycles(1, 1'b0, 1'b0, 4);
    run_cycles(10, 1'b1, 1'b0, 4);
    run_cycles(8, 1'b0, 1'b0, 4);

    $display("[TB] asynchronous reset mid-run");
    run_cycles(27, 1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    run_cycles(1, 1'b0, 1'b0, 4);
    run_cycles(12, 1'b1, 1'b0, 4);
    run_cycles(8, 1'b0, 1'b0, 4);

    $display("[TB] randomized run");
    cur_start  = 1'b0;
    cur_dir    = 1'b0;
    cur_period = 3;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) cur_start = ~cur_start;
      if ($urandom_range(0, 3) == 0)  cur_dir = ~cur_dir;
      if ($urandom_range(0, 15) == 0) cur_period = int'($urandom_range(0, 7));
      if ($urandom_range(0, 599) == 0) applyStimulus(1'b0, cur_start, cur_dir, cur_period);
      else                             applyStimulus(1'b1, cur_start, cur_dir, cur_period);
    end

    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if (q_exp[k].size() != 0) begin
        miscompares++;
        $display("[TB] FAIL drain%0d: got %0d pending expected 0", k, q_exp[k].size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
